// File: rtl/qam_pkg.sv
// Shared types and framing constants for the QAM frame sequencer.
package qam_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_HEADER,
    ST_PAYLOAD,
    ST_TAIL
  } state_e;

  localparam int unsigned LEN_W     = 5;
  localparam int unsigned CNT_W     = 8;
  localparam int unsigned TAIL_BITS = 4;

  localparam logic [2:0] HDR_SYNC      = 3'b101;
  localparam logic [3:0] PREAMBLE_PAIR = {2'b01, 2'b10};

  // Bit of the repeating 0,1,1,0 preamble pattern at position idx.
  function automatic logic preamble_bit(input logic [1:0] idx);
    return PREAMBLE_PAIR[2'd3 - idx];
  endfunction

endpackage

// File: rtl/qam_shift8.sv
// 8-bit parallel-in/serial-out register. A load emits data_i[7] immediately
// and keeps the remaining seven bits; last_bit_c_o flags the eighth bit.
module qam_shift8 (
  input  logic       clk,
  input  logic       reset,
  input  logic       load_i,
  input  logic       shift_i,
  input  logic [7:0] data_i,
  output logic       ser_c_o,
  output logic       last_bit_c_o
);

  logic [7:0] sr_q, sr_d;
  logic [2:0] cnt_q, cnt_d;

  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (load_i) begin
      sr_d  = {data_i[6:0], 1'b0};
      cnt_d = 3'd1;
    end else if (shift_i) begin
      sr_d  = {sr_q[6:0], 1'b0};
      cnt_d = cnt_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  assign ser_c_o      = load_i ? data_i[7] : sr_q[7];
  assign last_bit_c_o = shift_i && !load_i && (cnt_q == 3'd7);

endmodule

// File: rtl/qam_frame_ctrl.sv
// Frame sequencer for the 4-point QAM mapper: preamble, header, payload and
// zero tail, one registered bit per clock with symbol phase marking.
module qam_frame_ctrl
  import qam_pkg::*;
#(
  parameter int unsigned PREAMBLE_SYMS = 8,
  parameter int unsigned MAX_LEN       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [7:0]       din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             conv_S,
  output logic             bit_phase,
  output logic             busy,
  output logic             done,
  output logic             reject,
  output logic             underrun
);

  localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(2 * PREAMBLE_SYMS - 1);
  localparam logic [CNT_W-1:0] TAIL_LAST = CNT_W'(TAIL_BITS - 1);
  localparam logic [LEN_W-1:0] LEN_MAX   = LEN_W'(MAX_LEN);

  state_e state_q, state_d;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] byte_cnt_q, byte_cnt_d;
  logic conv_s_q, conv_s_d;
  logic bit_phase_q, bit_phase_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic reject_q, reject_d;
  logic din_ready_q, din_ready_d;
  logic underrun_q, underrun_d;

  logic       sh_load, sh_shift, sh_ser, sh_last;
  logic [7:0] sh_data;
  logic       start_seen, len_ok;

  // Starts are only looked at once the previous frame has fully retired.
  assign start_seen = start && (state_q == ST_IDLE) && !busy_q;
  assign len_ok     = (len != '0) && (len <= LEN_MAX);

  qam_shift8 u_shift8 (
    .clk          (clk),
    .reset        (reset),
    .load_i       (sh_load),
    .shift_i      (sh_shift),
    .data_i       (sh_data),
    .ser_c_o      (sh_ser),
    .last_bit_c_o (sh_last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:     if (start_seen && len_ok)     state_d = ST_PREAMBLE;
      ST_PREAMBLE: if (cnt_q == PRE_LAST)        state_d = ST_HEADER;
      ST_HEADER:   if (sh_last)                  state_d = ST_PAYLOAD;
      ST_PAYLOAD:  if (sh_last && byte_cnt_q == len_q) state_d = ST_TAIL;
      ST_TAIL:     if (cnt_q == TAIL_LAST)       state_d = ST_IDLE;
      default:                                   state_d = ST_IDLE;
    endcase
  end

  // State register holds the bit to emit next; outputs register it one edge later.
  always_comb begin
    cnt_d       = cnt_q;
    len_d       = len_q;
    byte_cnt_d  = byte_cnt_q;
    conv_s_d    = 1'b0;
    bit_phase_d = (state_q != ST_IDLE) && busy_q ? ~bit_phase_q : 1'b0;
    busy_d      = (state_q != ST_IDLE);
    done_d      = busy_q && (state_q == ST_IDLE);
    reject_d    = 1'b0;
    din_ready_d = 1'b0;
    underrun_d  = underrun_q;
    sh_load     = 1'b0;
    sh_shift    = 1'b0;
    sh_data     = din_valid ? din : 8'h00;

    unique case (state_q)
      ST_IDLE: begin
        if (start_seen) begin
          if (len_ok) begin
            len_d      = len;
            underrun_d = 1'b0;
            cnt_d      = '0;
            byte_cnt_d = '0;
          end else begin
            reject_d = 1'b1;
          end
        end
      end
      ST_PREAMBLE: begin
        conv_s_d = preamble_bit(cnt_q[1:0]);
        cnt_d    = (cnt_q == PRE_LAST) ? '0 : cnt_q + CNT_W'(1);
      end
      ST_HEADER: begin
        sh_load  = (cnt_q == '0);
        sh_shift = !sh_load;
        sh_data  = {HDR_SYNC, len_q};
        conv_s_d = sh_ser;
        cnt_d    = CNT_W'(1);
        if (sh_last) din_ready_d = 1'b1;
      end
      ST_PAYLOAD: begin
        sh_load  = din_ready_q;
        sh_shift = !din_ready_q;
        conv_s_d = sh_ser;
        if (din_ready_q) begin
          byte_cnt_d = byte_cnt_q + LEN_W'(1);
          if (!din_valid) underrun_d = 1'b1;
        end
        if (sh_last) begin
          if (byte_cnt_q != len_q) din_ready_d = 1'b1;
          else                     cnt_d       = '0;
        end
      end
      ST_TAIL: begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q       <= '0;
      len_q       <= '0;
      byte_cnt_q  <= '0;
      conv_s_q    <= 1'b0;
      bit_phase_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      reject_q    <= 1'b0;
      din_ready_q <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      byte_cnt_q  <= byte_cnt_d;
      conv_s_q    <= conv_s_d;
      bit_phase_q <= bit_phase_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      reject_q    <= reject_d;
      din_ready_q <= din_ready_d;
      underrun_q  <= underrun_d;
    end
  end

  assign conv_S    = conv_s_q;
  assign bit_phase = bit_phase_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign reject    = reject_q;
  assign din_ready = din_ready_q;
  assign underrun  = underrun_q;

endmodule
